// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core. One FSM sequences a shared ALU and register file
// through FETCH/DECODE/EXEC/MEM/WB over a single req/ready memory port.
module mips_multicycle_core #(
    parameter int unsigned       ADDR_W          = 32,
    parameter logic [ADDR_W-1:0] RESET_PC        = '0,
    parameter bit                HALT_ON_ILLEGAL = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              retire,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);
    localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_J = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [ADDR_W-1:0] J_MASK = ADDR_W'(32'h0FFF_FFFF);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] pc, t, j_target;
    logic [31:0]       ir, a, b, y, mdr;
    logic [31:0]       rf [32];
    logic              retire_q, retire_d;
    logic [5:0]        op, funct;
    logic [4:0]        rs, rt, rd, wb_dst;
    logic [31:0]       imm_sext, alu_b, alu_y, wb_val;
    logic              legal, unused_shamt;

    assign op           = ir[31:26];
    assign rs           = ir[25:21];
    assign rt           = ir[20:16];
    assign rd           = ir[15:11];
    assign funct        = ir[5:0];
    assign unused_shamt = ^ir[10:6];
    assign imm_sext     = {{16{ir[15]}}, ir[15:0]};
    assign legal        = (op == OP_R) ? (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT})
                                       : (op inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J});
    // Jump keeps the PC region bits above bit 27 and replaces the rest.
    assign j_target     = (pc & ~J_MASK) | (ADDR_W'({ir[25:0], 2'b00}) & J_MASK);
    assign wb_dst       = (op == OP_R) ? rd : rt;
    assign wb_val       = (op == OP_LW) ? mdr : y;

    // Shared ALU: addi/lw/sw all reduce to A + sext(imm).
    assign alu_b = (op == OP_R) ? b : imm_sext;
    always_comb begin
        alu_y = a + alu_b;
        if (op == OP_R) begin
            case (funct)
                FN_SUB:  alu_y = a - b;
                FN_AND:  alu_y = a & b;
                FN_OR:   alu_y = a | b;
                FN_SLT:  alu_y = {31'd0, $signed(a) < $signed(b)};
                default: alu_y = a + b;
            endcase
        end
    end

    // Request is gated by rst_n so an asserted reset kills a transfer immediately.
    assign mem_req   = rst_n & ((state == S_FETCH) | (state == S_MEM));
    assign mem_we    = rst_n & (state == S_MEM) & (op == OP_SW);
    assign mem_addr  = (state == S_MEM) ? ADDR_W'(y) : pc;
    assign mem_wdata = b;
    assign retire    = retire_q;
    assign pc_out    = pc;
    assign halted    = (state == S_HALT);

    always_comb begin
        state_d  = state;
        retire_d = 1'b0;
        case (state)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (legal) state_d = S_EXEC;
                else if (HALT_ON_ILLEGAL) state_d = S_HALT;
                else begin
                    state_d  = S_FETCH;
                    retire_d = 1'b1;
                end
            end
            S_EXEC: begin
                if (op == OP_LW || op == OP_SW) state_d = (alu_y[1:0] != 2'b00) ? S_HALT : S_MEM;
                else if (op == OP_BEQ || op == OP_J) begin
                    state_d  = S_FETCH;
                    retire_d = 1'b1;
                end else state_d = S_WB;
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d  = (op == OP_SW) ? S_FETCH : S_WB;
                    retire_d = (op == OP_SW);
                end
            end
            S_WB: begin
                state_d  = S_FETCH;
                retire_d = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            retire_q <= 1'b0;
            pc       <= RESET_PC;
            t        <= '0;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            y        <= '0;
            mdr      <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            state    <= state_d;
            retire_q <= retire_d;
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir <= mem_rdata;
                    pc <= pc + ADDR_W'(4);
                end
                S_DECODE: begin
                    a <= rf[rs];
                    b <= rf[rt];
                    t <= pc + ADDR_W'(imm_sext << 2);
                end
                S_EXEC: begin
                    y <= alu_y;
                    if (op == OP_BEQ && a == b) pc <= t;
                    if (op == OP_J) pc <= j_target;
                end
                S_MEM:   if (mem_ready && op == OP_LW) mdr <= mem_rdata;
                S_WB:    if (wb_dst != 5'd0) rf[wb_dst] <= wb_val;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: wait-state memory model, ISA-level reference
// interpreter stepped on every retire, plus directed halt/reset/NOP-mode cases.
module tb_mips_multicycle_core;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        mem_req, mem_we, mem_ready = 1'b0, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0, pc_out;
    logic        n_req, n_we, n_retire, n_halted, n_ready = 1'b1;
    logic [7:0]  n_addr, n_pc;
    logic [31:0] n_wdata, n_rdata = 32'hFC00_0000;

    mips_multicycle_core dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .retire(retire), .pc_out(pc_out), .halted(halted));

    mips_multicycle_core #(.ADDR_W(8), .RESET_PC(8'hF0), .HALT_ON_ILLEGAL(1'b0)) dut_nop (
        .clk(clk), .rst_n(rst_n), .mem_req(n_req), .mem_we(n_we), .mem_addr(n_addr),
        .mem_wdata(n_wdata), .mem_rdata(n_rdata), .mem_ready(n_ready),
        .retire(n_retire), .pc_out(n_pc), .halted(n_halted));

    initial forever #5 clk = ~clk;

    int          checks = 0, passed = 0, fails = 0;
    int          since, ws, last_lat, fix_w = 0, pa;
    bit          first, rand_w = 1'b0;
    logic [31:0] mem [256];
    logic [31:0] m_mem [256];
    logic [31:0] m_reg [32];
    logic [31:0] m_pc, m_sa, m_sd;
    int          m_base;
    bit          m_st, m_halt;
    logic [63:0] st_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic put(input logic [31:0] w);
        mem[pa] = w;
        m_mem[pa] = w;
        pa++;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            m_mem[i] = '0;
        end
        pa = 0;
    endtask

    // ISA interpreter: executes one instruction from m_mem in architectural terms.
    task automatic model_step();
        logic [31:0] ins, av, bv, imm, ea, res;
        logic [4:0]  dst;
        bit          wr;
        ins = m_mem[m_pc[9:2]];
        av  = m_reg[ins[25:21]];
        bv  = m_reg[ins[20:16]];
        imm = {{16{ins[15]}}, ins[15:0]};
        m_pc = m_pc + 32'd4;
        m_st = 1'b0; wr = 1'b0; m_base = 4; dst = ins[20:16]; res = '0;
        case (ins[31:26])
            6'h00: begin
                dst = ins[15:11]; wr = 1'b1;
                case (ins[5:0])
                    6'h20: res = av + bv;
                    6'h22: res = av - bv;
                    6'h24: res = av & bv;
                    6'h25: res = av | bv;
                    6'h2A: res = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
                    default: begin wr = 1'b0; m_halt = 1'b1; end
                endcase
            end
            6'h08: begin res = av + imm; wr = 1'b1; end
            6'h23: begin
                ea = av + imm;
                if (ea[1:0] != 2'b00) m_halt = 1'b1;
                else begin res = m_mem[ea[9:2]]; wr = 1'b1; m_base = 5; end
            end
            6'h2B: begin
                ea = av + imm;
                if (ea[1:0] != 2'b00) m_halt = 1'b1;
                else begin m_mem[ea[9:2]] = bv; m_st = 1'b1; m_sa = ea; m_sd = bv; end
            end
            6'h04: begin m_base = 3; if (av == bv) m_pc = m_pc + (imm << 2); end
            6'h02: begin m_base = 3; m_pc = {m_pc[31:28], ins[25:0], 2'b00}; end
            default: m_halt = 1'b1;
        endcase
        if (wr && dst != 5'd0) m_reg[dst] = res;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        m_pc = '0; m_halt = 1'b0; since = 0; ws = 0; first = 1'b1;
        st_q.delete();
    endtask

    // Runs until n retires; each retire steps the model and checks pc, latency, stores.
    task automatic run(input int n);
        int got, cyc;
        logic [63:0] e;
        got = 0; cyc = 0;
        while (got < n && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (retire) begin
                model_step();
                if (!first) begin
                    chk("latency", since, m_base + ws);
                    last_lat = since;
                end
                first = 1'b0;
                chk("pc", pc_out, m_pc);
                if (m_st) begin
                    chk("store_count", st_q.size(), 1);
                    if (st_q.size() > 0) begin
                        e = st_q.pop_front();
                        chk("store_addr", e[63:32], m_sa);
                        chk("store_data", e[31:0], m_sd);
                    end
                end
                since = 0; ws = 0; got++;
            end
            since++;
            if (mem_req && !mem_ready) ws++;
        end
        chk("retired", got, n);
    endtask

    // Memory responder: per-access wait count, hold-stability checks, store log.
    bit          busy = 1'b0, h_we;
    int          wc, tgt;
    logic [31:0] h_addr, h_wd;
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n || !mem_req) begin
            mem_ready = 1'b0;
            busy = 1'b0;
        end else begin
            if (!busy) begin
                busy = 1'b1; wc = 0;
                tgt = rand_w ? int'($urandom_range(0, 2)) : fix_w;
                h_addr = mem_addr; h_we = mem_we; h_wd = mem_wdata;
            end else begin
                chk("hold_addr", mem_addr, h_addr);
                chk("hold_we", {31'd0, mem_we}, {31'd0, h_we});
                if (h_we) chk("hold_wdata", mem_wdata, h_wd);
            end
            if (wc >= tgt) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[9:2]];
                if (mem_we) begin
                    mem[mem_addr[9:2]] = mem_wdata;
                    st_q.push_back({mem_addr, mem_wdata});
                end
                busy = 1'b0;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                wc++;
            end
        end
    end

    initial begin
        int cnt, c, lastc, gap, reqs, rets;
        logic [4:0] r1, r2, r3;

        // Directed program: arithmetic, load/store, branches, jump, tight loop.
        clear_mem();
        put(enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put(enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
        put(enc_r(5'd1, 5'd2, 5'd3, 6'h20));
        put(enc_i(6'h2B, 5'd0, 5'd3, 16'h0100));
        put(enc_i(6'h2B, 5'd0, 5'd3, 16'h0188));
        put(enc_i(6'h23, 5'd0, 5'd4, 16'h0188));
        put(enc_i(6'h2B, 5'd0, 5'd4, 16'h0104));
        put(enc_i(6'h04, 5'd1, 5'd2, 16'd5));
        put(enc_i(6'h04, 5'd1, 5'd1, 16'd0));
        put(enc_i(6'h23, 5'd0, 5'd6, 16'h0140));
        put(enc_i(6'h08, 5'd0, 5'd7, 16'd1));
        put(enc_r(5'd6, 5'd7, 5'd8, 6'h22));
        put(enc_i(6'h2B, 5'd0, 5'd8, 16'h0108));
        put(enc_i(6'h08, 5'd0, 5'd5, 16'hFFFF));
        put(enc_r(5'd5, 5'd7, 5'd9, 6'h2A));
        put(enc_i(6'h2B, 5'd0, 5'd9, 16'h010C));
        put(enc_i(6'h08, 5'd0, 5'd0, 16'd7));
        put(enc_i(6'h2B, 5'd0, 5'd0, 16'h0110));
        put(enc_r(5'd1, 5'd2, 5'd10, 6'h24));
        put(enc_r(5'd1, 5'd2, 5'd11, 6'h25));
        put(enc_i(6'h2B, 5'd0, 5'd10, 16'h0114));
        put(enc_i(6'h2B, 5'd0, 5'd11, 16'h0118));
        put({6'h02, 26'd24});
        put(enc_i(6'h08, 5'd0, 5'd12, 16'd99));
        put(enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF));
        mem[80] = 32'h8000_0000;
        m_mem[80] = 32'h8000_0000;

        fix_w = 0; rand_w = 1'b0;
        do_reset();
        run(3);
        chk("addi_add_latency", last_lat, 4);
        fix_w = 3;
        run(1);
        run(2);
        chk("lw_wait_latency", last_lat, 11);
        run(1);
        rand_w = 1'b1;
        run(16);
        rand_w = 1'b0; fix_w = 0;
        run(4);
        chk("beq_loop_pc", pc_out, 32'h60);
        chk("beq_loop_latency", last_lat, 3);
        chk("mem_add", mem[64], 32'd2);
        chk("mem_lw_copy", mem[65], 32'd2);
        chk("mem_sub_wrap", mem[66], 32'h7FFF_FFFF);
        chk("mem_slt", mem[67], 32'd1);
        chk("mem_r0", mem[68], 32'd0);
        chk("mem_and", mem[69], 32'd5);
        chk("mem_or", mem[70], 32'hFFFF_FFFD);

        // Randomized ALU programs checked store-by-store against the interpreter.
        for (int it = 0; it < 3; it++) begin
            clear_mem();
            for (int r = 1; r < 8; r++) put(enc_i(6'h08, 5'd0, 5'(r), 16'($urandom)));
            for (int k = 0; k < 20; k++) begin
                r1 = 5'($urandom_range(1, 7));
                r2 = 5'($urandom_range(1, 7));
                r3 = 5'($urandom_range(0, 7));
                case ($urandom_range(0, 5))
                    0: put(enc_r(r1, r2, r3, 6'h20));
                    1: put(enc_r(r1, r2, r3, 6'h22));
                    2: put(enc_r(r1, r2, r3, 6'h24));
                    3: put(enc_r(r1, r2, r3, 6'h25));
                    4: put(enc_r(r1, r2, r3, 6'h2A));
                    default: put(enc_i(6'h08, r1, r3, 16'($urandom)));
                endcase
            end
            for (int r = 0; r < 8; r++) put(enc_i(6'h2B, 5'd0, 5'(r), 16'(32'h200 + 4 * r)));
            put(enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
            rand_w = 1'b1;
            do_reset();
            run(37);
        end
        rand_w = 1'b0; fix_w = 0;

        // Misaligned load halts with no further requests.
        clear_mem();
        put(enc_i(6'h08, 5'd0, 5'd1, 16'd3));
        put(enc_i(6'h23, 5'd1, 5'd2, 16'd0));
        do_reset();
        run(1);
        repeat (5) @(negedge clk);
        reqs = 0; rets = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_req) reqs++;
            if (retire) rets++;
        end
        chk("misaligned_halted", {31'd0, halted}, 32'd1);
        chk("misaligned_no_req", reqs, 0);
        chk("misaligned_no_retire", rets, 0);
        chk("misaligned_pc", pc_out, 32'h8);

        // Illegal opcode halts.
        clear_mem();
        put(32'hFC00_0000);
        do_reset();
        repeat (6) @(negedge clk);
        chk("illegal_halted", {31'd0, halted}, 32'd1);
        chk("illegal_no_req", {31'd0, mem_req}, 32'd0);
        chk("illegal_pc", pc_out, 32'h4);

        // Reset dropped during a fetch wait aborts the request at once.
        clear_mem();
        put(enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put(enc_i(6'h08, 5'd0, 5'd2, 16'd6));
        put(enc_i(6'h08, 5'd0, 5'd3, 16'd7));
        do_reset();
        run(1);
        fix_w = 6;
        repeat (5) @(negedge clk);
        chk("pre_abort_req", {31'd0, mem_req}, 32'd1);
        chk("pre_abort_addr", mem_addr, 32'h8);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_req_async", {31'd0, mem_req}, 32'd0);
        chk("abort_pc_async", pc_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("refetch_req", {31'd0, mem_req}, 32'd1);
        chk("refetch_addr", mem_addr, 32'd0);
        fix_w = 0;

        // NOP-mode instance: illegal words retire every 2 cycles and the 8-bit PC wraps.
        do_reset();
        cnt = 0; c = 0; lastc = 0; gap = 0;
        while (cnt < 4 && c < 100) begin
            @(negedge clk);
            c++;
            if (n_retire) begin
                cnt++;
                if (cnt == 3) gap = c - lastc;
                lastc = c;
            end
        end
        chk("nop_retires", cnt, 4);
        chk("nop_gap", gap, 2);
        chk("nop_pc_wrap", {24'd0, n_pc}, 32'd0);
        chk("nop_not_halted", {31'd0, n_halted}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
